// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the VGA sync generator and downstream pixel logic.
//   en          : pixel enable (into the generator)
//   hsync/vsync : sync pulses, polarity set by the generator
//   video_on    : visible-area flag
//   px_x/px_y   : current pixel coordinates
//   line_start  : first pixel of a line
//   frame_start : first pixel of a frame
interface vga_sync_gen_if #(
    parameter int unsigned CW = 10
);
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] px_x;
    logic [CW-1:0] px_y;
    logic          line_start;
    logic          frame_start;

    // Generator side
    modport master (
        input  en,
        output hsync, vsync, video_on, px_x, px_y, line_start, frame_start
    );

    // Consumer side
    modport slave (
        output en,
        input  hsync, vsync, video_on, px_x, px_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Pixel timing generator: free-running h/v counters decoded into sync,
// visible-area flag, coordinates and line/frame start pulses. Every output
// is registered from the same counter value, so all outputs describe the
// same pixel one cycle after the counter held it.
//   clk : pixel clock
//   rst : asynchronous active-high reset
//   bus : vga_sync_gen_if master (en in, timing outputs out)
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned CW        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_sync_gen_if.master        bus
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          hs_act;
    logic          vs_act;
    logic          vis;

    // Counter advance: v steps only on the h wrap, frame wraps on both
    always_comb begin
        h_nxt = h_cnt + CW'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
        end
    end

    // Decode of the current counter position
    always_comb begin
        hs_act = (h_cnt >= HS_START) && (h_cnt <= HS_END);
        vs_act = (v_cnt >= VS_START) && (v_cnt <= VS_END);
        vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    end

    // Counters and output registers share one enable so nothing skews
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
            bus.video_on    <= 1'b0;
            bus.px_x        <= '0;
            bus.px_y        <= '0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else if (bus.en) begin
            h_cnt           <= h_nxt;
            v_cnt           <= v_nxt;
            bus.hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            bus.vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            bus.video_on    <= vis;
            bus.px_x        <= h_cnt;
            bus.px_y        <= v_cnt;
            bus.line_start  <= (h_cnt == '0);
            bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel timing generator for the VGA path. Runs on the 25 MHz pixel clock produced by the clock divider stage.
- Produces horizontal/vertical sync, a visible-area flag and the current pixel coordinates. Downstream pixel/colour logic consumes these.
- Defaults give 640x480 @ 60 Hz. All timing fields are parameters, so other modes reuse the block.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- CW, 10, width of counters and coordinate outputs

Ports:
- clk  in  1  pixel clock (25 MHz from divider)
- rst  in  1  asynchronous, active-high reset
- en  in  1  pixel enable; tie high when clk is the pixel clock; when low, all state holds
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high while the output position is in the visible area
- px_x  out  CW  horizontal position, 0..H_TOTAL-1
- px_y  out  CW  vertical position, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when px_x==0
- frame_start  out  1  one-cycle pulse when px_x==0 and px_y==0

Behaviour:
- Derived constants: H_TOTAL = sum of the H fields (800); V_TOTAL = sum of the V fields (525).
- Sync windows:
  - HS_START = H_VISIBLE+H_FRONT (656); HS_END = HS_START+H_SYNC-1 (751).
  - VS_START = V_VISIBLE+V_FRONT (490); VS_END = VS_START+V_SYNC-1 (491).
- Internal counters h_cnt and v_cnt are CW bits wide. CW must hold H_TOTAL-1 and V_TOTAL-1.
- Reset (asynchronous, rst=1), effective immediately and mid-frame:
  - h_cnt=0, v_cnt=0.
  - hsync=vsync=~SYNC_POL (inactive).
  - video_on=0, px_x=0, px_y=0, line_start=0, frame_start=0.
- Each rising clk edge with en=1:
  - Outputs are loaded from the decode of the current (h_cnt, v_cnt).
  - Counters then advance: h_cnt wraps H_TOTAL-1 -> 0. v_cnt increments only on h wrap, and wraps V_TOTAL-1 -> 0 when both wrap in the same cycle.
- Output decode:
  - px_x=h_cnt, px_y=v_cnt.
  - video_on = (h_cnt<H_VISIBLE) & (v_cnt<V_VISIBLE).
  - hsync = SYNC_POL when HS_START<=h_cnt<=HS_END, else ~SYNC_POL.
  - vsync = SYNC_POL when VS_START<=v_cnt<=VS_END, else ~SYNC_POL.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 & v_cnt==0).
- Latency and alignment:
  - Fixed 1 cycle from counter to outputs.
  - All outputs in a given cycle describe the same pixel; no skew between sync, video_on and coordinates.
  - vsync changes only in cycles where px_x==0.
- First edge after reset release (en=1): outputs show (0,0), video_on=1, line_start=1, frame_start=1.
- en=0:
  - Counters and every output register hold their value, including pulse outputs. Downstream qualifies pulses with en.
  - Resuming en=1 continues from the held position; no position is skipped.
- Frame period: exactly H_TOTAL*V_TOTAL enabled cycles (420000).
- Line period: H_TOTAL enabled cycles.
- Counters never reach values >= H_TOTAL or V_TOTAL.

Test Plan:
- Reset: rst=1 mid-line (h=300, v=200), then release; en=1 -> while rst is asserted, hsync=vsync=1, video_on=0, px=0. First edge after release gives px=(0,0), frame_start=1, video_on=1.
- Horizontal timing: run one line -> video_on high for px_x 0..639. hsync low exactly for px_x 656..751 (96 cycles). px_x 799 is followed by 0, with px_y incremented and line_start=1.
- Vertical timing: run one full frame -> vsync low only for px_y 490..491 (1600 cycles), asserting and deasserting at px_x==0. video_on=0 for all px_y>=480. frame_start pulses exactly once every 420000 cycles.
- Wrap: run to px=(799,524) -> next cycle px=(0,0) with frame_start=1 and line_start=1. No out-of-range coordinate is ever observed.
- Enable gating: drop en for 7 cycles at px=(638,0) -> all outputs frozen for 7 cycles. After en returns, the next positions are 639 and then 640, with video_on 1 then 0.
- Polarity/parameters: SYNC_POL=1 with a small mode (H fields 4,1,2,1; V fields 3,1,1,1) -> hsync high only at px_x 5..6. vsync high only at px_y 4. Frame period = 8*6 = 48 cycles.
